// File: rtl/vxc_pkg.sv
// -----------------------------------------------------------------------------
// vxc_pkg
// Shared definitions for the vector-by-constant row server:
//   - default element width and lane count
//   - row_t: one full row of NO_OF_UNITS elements
//   - state_e: pass sequencing states
//   - helpers that size the row RAMs from the equation count
// -----------------------------------------------------------------------------
package vxc_pkg;

  localparam int VXC_ELEMENT_WIDTH = 32;
  localparam int VXC_NO_OF_UNITS   = 8;

  typedef logic [VXC_ELEMENT_WIDTH*VXC_NO_OF_UNITS-1:0] row_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Rows needed to hold all equations; never fewer than one.
  function automatic int vxc_num_rows(input int num_eq, input int units);
    int rows;
    rows = (num_eq + units - 1) / units;
    return (rows < 1) ? 1 : rows;
  endfunction

  // Address width for a given depth; a one-row RAM still gets a 1-bit address.
  function automatic int vxc_clog2_min1(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/vxc_row_ram.sv
// -----------------------------------------------------------------------------
// vxc_row_ram
// Simple dual-port row RAM: one write port, one synchronous read port.
// Depth DEPTH rows of WIDTH bits; maps onto block RAM with its output register.
// Ports:
//   clk      clock
//   srst     synchronous reset of the read data register only (contents kept)
//   we_i     write enable
//   waddr_i  write row address
//   wdata_i  write row data
//   re_i     read enable; rdata_o updates on the next edge, holds otherwise
//   raddr_i  read row address
//   rdata_o  registered read data (read-first on a same-address collision)
// -----------------------------------------------------------------------------
module vxc_row_ram #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 256,
  parameter int AW    = 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Addresses beyond DEPTH (non power-of-two depth) are dropped on write
  // and read back as zero.
  always_ff @(posedge clk) begin
    if (we_i && (int'(waddr_i) < DEPTH)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= (int'(raddr_i) < DEPTH) ? mem_q[raddr_i] : '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/vxc_row_server.sv
// -----------------------------------------------------------------------------
// vxc_row_server
// Memory-side partner of the vector-by-constant consumer. Holds two operand
// row sets, serves one row per read_again, captures each result row on
// result_mem_we, and sequences one pass per start pulse.
//
// Optional feature macro: VXC_ROW_SERVER_TIMEOUT_EN
//   When defined, a watchdog forces DONE (with err) if no result row arrives
//   for TIMEOUT_CYCLES cycles while busy.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   load_we/sel/addr/data operand row writes (IDLE only); sel 0 = first rows
//   start                begin a pass (IDLE or DONE only)
//   cfg_constant, cfg_op latched on an accepted start
//   core_reset           consumer reset; low only while serving a pass
//   first_row_fixed      current first operand row (registered)
//   second_row_fixed     current second operand row (registered)
//   constant, op         latched configuration
//   read_again           consumer has taken the current row
//   result_mem_we        result row valid on vXc_add_8_output
//   res_rd_addr/data     result readback, 1-cycle latency
//   busy, done, err      status: busy in SERVE/DRAIN, done pulse, sticky error
// -----------------------------------------------------------------------------
module vxc_row_server
  import vxc_pkg::*;
#(
  parameter int  ELEMENT_WIDTH  = VXC_ELEMENT_WIDTH,
  parameter int  NO_OF_UNITS    = VXC_NO_OF_UNITS,
  parameter int  NUM_EQUATIONS  = 16,
  parameter int  TIMEOUT_CYCLES = 64,
  localparam int NUM_ROWS       = vxc_num_rows(NUM_EQUATIONS, NO_OF_UNITS),
  localparam int AW             = vxc_clog2_min1(NUM_ROWS),
  localparam int RW             = ELEMENT_WIDTH * NO_OF_UNITS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_we,
  input  logic                     load_sel,
  input  logic [AW-1:0]            load_addr,
  input  logic [RW-1:0]            load_data,
  input  logic                     start,
  input  logic [ELEMENT_WIDTH-1:0] cfg_constant,
  input  logic                     cfg_op,
  output logic                     core_reset,
  output logic [RW-1:0]            first_row_fixed,
  output logic [RW-1:0]            second_row_fixed,
  output logic [ELEMENT_WIDTH-1:0] constant,
  output logic                     op,
  input  logic                     read_again,
  input  logic                     result_mem_we,
  input  logic [RW-1:0]            vXc_add_8_output,
  input  logic [AW-1:0]            res_rd_addr,
  output logic [RW-1:0]            res_rd_data,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  // Pointers must be able to hold NUM_ROWS itself ("all rows consumed").
  localparam int             PW       = $clog2(NUM_ROWS + 1);
  localparam logic [PW-1:0]  LAST_PTR = PW'(NUM_ROWS);

  state_e                     state_q, state_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [ELEMENT_WIDTH-1:0]   constant_q, constant_d;
  logic                       op_q, op_d;
  logic                       err_q, err_d;
  logic                       done_q, done_d;
  logic                       busy_q, busy_d;
  logic                       core_reset_q, core_reset_d;

  logic                       active;
  logic                       start_ok;
  logic                       ra_ok;
  logic                       ra_err;
  logic                       we_ok;
  logic                       we_err;
  logic                       load_ok;
  logic                       timeout;

  logic                       op_we [2];
  logic                       op_re;
  logic [AW-1:0]              op_raddr;
  logic [RW-1:0]              row_rdata [2];

  // ---------------------------------------------------------------------------
  // Request qualification
  // ---------------------------------------------------------------------------
  always_comb begin
    active   = (state_q == SERVE) || (state_q == DRAIN);
    start_ok = start && ((state_q == IDLE) || (state_q == DONE));
    ra_ok    = read_again && active && (rd_ptr_q != LAST_PTR);
    ra_err   = read_again && active && (rd_ptr_q == LAST_PTR);
    we_ok    = result_mem_we && active;
    we_err   = result_mem_we && !active;
    load_ok  = load_we && (state_q == IDLE);
    op_we[0] = load_ok && !load_sel;
    op_we[1] = load_ok && load_sel;
    // A start always presents row 0; otherwise the next unread row.
    op_re    = start_ok || ra_ok;
    op_raddr = start_ok ? '0 : rd_ptr_q[AW-1:0];
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    constant_d = constant_q;
    op_d       = op_q;
    err_d      = err_q;

    case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          state_d    = SERVE;
          rd_ptr_d   = PW'(1);
          wr_ptr_d   = '0;
          constant_d = cfg_constant;
          op_d       = cfg_op;
          err_d      = 1'b0;
        end
      end
      SERVE, DRAIN: begin
        if (ra_ok) begin
          rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (we_ok) begin
          wr_ptr_d = wr_ptr_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Once every row has been handed out only results remain outstanding.
    if ((state_d == SERVE) && (rd_ptr_d == LAST_PTR)) begin
      state_d = DRAIN;
    end

    // The last result row (or a watchdog expiry) ends the pass.
    if ((we_ok && (wr_ptr_d == LAST_PTR)) || timeout) begin
      state_d = DONE;
    end

    // Errors are set after the start clear so a same-cycle error is kept.
    if (ra_err || we_err || timeout) begin
      err_d = 1'b1;
    end
  end

  always_comb begin
    busy_d       = (state_d == SERVE) || (state_d == DRAIN);
    core_reset_d = !busy_d;
    done_d       = (state_d == DONE) && (state_q != DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      constant_q   <= '0;
      op_q         <= 1'b0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      constant_q   <= constant_d;
      op_q         <= op_d;
      err_q        <= err_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      core_reset_q <= core_reset_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Watchdog: cycles while busy since start or the last result write
  // ---------------------------------------------------------------------------
`ifdef VXC_ROW_SERVER_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDW-1:0] wdog_q, wdog_d;

  always_comb begin
    wdog_d  = wdog_q;
    timeout = 1'b0;
    if (!active || start_ok || we_ok) begin
      wdog_d = '0;
    end else if (wdog_q == WDW'(TIMEOUT_CYCLES - 1)) begin
      timeout = 1'b1;
      wdog_d  = '0;
    end else begin
      wdog_d = wdog_q + WDW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Operand RAMs (index 0 = first rows, 1 = second rows). Their read
  // registers are the row outputs, so rows hold between requests.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_operand_ram
    vxc_row_ram #(
      .DEPTH (NUM_ROWS),
      .WIDTH (RW),
      .AW    (AW)
    ) u_ram (
      .clk     (clk),
      .srst    (reset),
      .we_i    (op_we[gi]),
      .waddr_i (load_addr),
      .wdata_i (load_data),
      .re_i    (op_re),
      .raddr_i (op_raddr),
      .rdata_o (row_rdata[gi])
    );
  end

  // Result RAM: written from the consumer, readable in any state.
  vxc_row_ram #(
    .DEPTH (NUM_ROWS),
    .WIDTH (RW),
    .AW    (AW)
  ) u_result_ram (
    .clk     (clk),
    .srst    (reset),
    .we_i    (we_ok),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (vXc_add_8_output),
    .re_i    (1'b1),
    .raddr_i (res_rd_addr),
    .rdata_o (res_rd_data)
  );

  assign first_row_fixed  = row_rdata[0];
  assign second_row_fixed = row_rdata[1];
  assign constant         = constant_q;
  assign op               = op_q;
  assign core_reset       = core_reset_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;

endmodule

// File: tb/tb_vxc_row_server.sv
// -----------------------------------------------------------------------------
// tb_vxc_row_server
// Directed vector table, hand-written corner sequences and a randomized phase
// checked against a pass-level reference model of the row server.
// -----------------------------------------------------------------------------
module tb_vxc_row_server;

  localparam int EW = 32;
  localparam int NU = 8;
  localparam int NR = 2;
  localparam int AW = 1;
  localparam int RW = EW * NU;

  localparam logic [RW-1:0] Z  = '0;
  localparam logic [RW-1:0] R1 = {NU{32'h0000_0001}};
  localparam logic [RW-1:0] R2 = {NU{32'h0000_0002}};
  localparam logic [RW-1:0] S1 = {NU{32'h0000_0011}};
  localparam logic [RW-1:0] S2 = {NU{32'h0000_0012}};
  localparam logic [RW-1:0] RA = {NU{32'hAAAA_AAAA}};
  localparam logic [RW-1:0] RB = {NU{32'hBBBB_BBBB}};
  localparam logic [RW-1:0] RC = {NU{32'hCCCC_0001}};
  localparam logic [RW-1:0] RD = {NU{32'hDDDD_0002}};
  localparam logic [RW-1:0] RE = {NU{32'hEEEE_0003}};
  localparam logic [RW-1:0] RF = {NU{32'hFFFF_0004}};
  localparam logic [RW-1:0] RG = {NU{32'h1234_5678}};
  localparam logic [RW-1:0] RH = {NU{32'h8765_4321}};
  localparam logic [EW-1:0] CST = 32'h0000_0005;

  logic          clk;
  logic          reset;
  logic          load_we;
  logic          load_sel;
  logic [AW-1:0] load_addr;
  logic [RW-1:0] load_data;
  logic          start;
  logic [EW-1:0] cfg_constant;
  logic          cfg_op;
  logic          core_reset;
  logic [RW-1:0] first_row_fixed;
  logic [RW-1:0] second_row_fixed;
  logic [EW-1:0] constant;
  logic          op;
  logic          read_again;
  logic          result_mem_we;
  logic [RW-1:0] vXc_add_8_output;
  logic [AW-1:0] res_rd_addr;
  logic [RW-1:0] res_rd_data;
  logic          busy;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;

  vxc_row_server dut (
    .clk              (clk),
    .reset            (reset),
    .load_we          (load_we),
    .load_sel         (load_sel),
    .load_addr        (load_addr),
    .load_data        (load_data),
    .start            (start),
    .cfg_constant     (cfg_constant),
    .cfg_op           (cfg_op),
    .core_reset       (core_reset),
    .first_row_fixed  (first_row_fixed),
    .second_row_fixed (second_row_fixed),
    .constant         (constant),
    .op               (op),
    .read_again       (read_again),
    .result_mem_we    (result_mem_we),
    .vXc_add_8_output (vXc_add_8_output),
    .res_rd_addr      (res_rd_addr),
    .res_rd_data      (res_rd_data),
    .busy             (busy),
    .done             (done),
    .err              (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "time limit reached");
  end

  typedef struct {
    logic          load_we;
    logic          load_sel;
    logic [AW-1:0] load_addr;
    logic [RW-1:0] load_data;
    logic          start;
    logic          read_again;
    logic          res_we;
    logic [RW-1:0] res_data;
    logic [AW-1:0] rd_addr;
    logic          chk_res;
    logic [RW-1:0] exp_res;
    logic          exp_cr;
    logic          exp_busy;
    logic          exp_done;
    logic          exp_err;
    logic [RW-1:0] exp_first;
    logic [RW-1:0] exp_second;
    logic [EW-1:0] exp_const;
    logic          exp_op;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    load_we       = 1'b0;
    start         = 1'b0;
    read_again    = 1'b0;
    result_mem_we = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic cr, input logic bz, input logic dn, input logic er);
    check({tag, " core_reset"}, RW'(core_reset), RW'(cr));
    check({tag, " busy"},       RW'(busy),       RW'(bz));
    check({tag, " done"},       RW'(done),       RW'(dn));
    check({tag, " err"},        RW'(err),        RW'(er));
  endtask

  function automatic logic [RW-1:0] rand_row();
    logic [RW-1:0] r;
    for (int k = 0; k < NU; k++) r[k*EW +: EW] = $urandom();
    return r;
  endfunction

  // Reference model state (pass-level view of the server)
  logic [RW-1:0] m_ops [2][NR];
  logic [RW-1:0] m_res [NR];
  bit            m_res_valid [NR];
  bit            m_idle, m_busy, m_done, m_err, m_op;
  int            m_rd, m_wr;
  logic [RW-1:0] m_first, m_second;
  logic [EW-1:0] m_const;

  initial begin
    logic [RW-1:0] exp_res;
    bit            exp_res_valid;
    int            n;
    int            passes;

    clr();
    reset            = 1'b1;
    load_sel         = 1'b0;
    load_addr        = '0;
    load_data        = '0;
    cfg_constant     = '0;
    cfg_op           = 1'b0;
    vXc_add_8_output = '0;
    res_rd_addr      = '0;

    // ---------------- reset state ----------------
    step();
    step();
    check_status("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    check("reset first_row",  first_row_fixed,  Z);
    check("reset second_row", second_row_fixed, Z);
    check("reset constant",   RW'(constant),    Z);
    check("reset op",         RW'(op),          Z);
    reset = 1'b0;

    // ---------------- directed vector table ----------------
    tbl[0]  = '{1'b1,1'b0,1'b0,R1, 1'b0,1'b0,1'b0,Z, 1'b0,1'b0,Z, 1'b1,1'b0,1'b0,1'b0, Z, Z, 32'h0,1'b0};
    tbl[1]  = '{1'b1,1'b0,1'b1,R2, 1'b0,1'b0,1'b0,Z, 1'b0,1'b0,Z, 1'b1,1'b0,1'b0,1'b0, Z, Z, 32'h0,1'b0};
    tbl[2]  = '{1'b1,1'b1,1'b0,S1, 1'b0,1'b0,1'b0,Z, 1'b0,1'b0,Z, 1'b1,1'b0,1'b0,1'b0, Z, Z, 32'h0,1'b0};
    tbl[3]  = '{1'b1,1'b1,1'b1,S2, 1'b0,1'b0,1'b0,Z, 1'b0,1'b0,Z, 1'b1,1'b0,1'b0,1'b0, Z, Z, 32'h0,1'b0};
    tbl[4]  = '{1'b0,1'b0,1'b0,Z,  1'b1,1'b0,1'b0,Z, 1'b0,1'b0,Z, 1'b0,1'b1,1'b0,1'b0, R1,S1,CST,1'b1};
    tbl[5]  = '{1'b0,1'b0,1'b0,Z,  1'b0,1'b0,1'b0,Z, 1'b0,1'b0,Z, 1'b0,1'b1,1'b0,1'b0, R1,S1,CST,1'b1};
    tbl[6]  = '{1'b0,1'b0,1'b0,Z,  1'b0,1'b1,1'b0,Z, 1'b0,1'b0,Z, 1'b0,1'b1,1'b0,1'b0, R2,S2,CST,1'b1};
    tbl[7]  = '{1'b0,1'b0,1'b0,Z,  1'b0,1'b0,1'b1,RA,1'b0,1'b0,Z, 1'b0,1'b1,1'b0,1'b0, R2,S2,CST,1'b1};
    tbl[8]  = '{1'b0,1'b0,1'b0,Z,  1'b0,1'b0,1'b1,RB,1'b0,1'b0,Z, 1'b1,1'b0,1'b1,1'b0, R2,S2,CST,1'b1};
    tbl[9]  = '{1'b0,1'b0,1'b0,Z,  1'b0,1'b0,1'b0,Z, 1'b1,1'b1,RB,1'b1,1'b0,1'b0,1'b0, R2,S2,CST,1'b1};
    tbl[10] = '{1'b0,1'b0,1'b0,Z,  1'b0,1'b0,1'b0,Z, 1'b0,1'b1,RA,1'b1,1'b0,1'b0,1'b0, R2,S2,CST,1'b1};

    for (int i = 0; i < 11; i++) begin
      load_we          = tbl[i].load_we;
      load_sel         = tbl[i].load_sel;
      load_addr        = tbl[i].load_addr;
      load_data        = tbl[i].load_data;
      start            = tbl[i].start;
      read_again       = tbl[i].read_again;
      result_mem_we    = tbl[i].res_we;
      vXc_add_8_output = tbl[i].res_data;
      res_rd_addr      = tbl[i].rd_addr;
      cfg_constant     = CST;
      cfg_op           = 1'b1;
      step();
      check_status($sformatf("vec%0d", i), tbl[i].exp_cr, tbl[i].exp_busy, tbl[i].exp_done, tbl[i].exp_err);
      check($sformatf("vec%0d first_row", i),  first_row_fixed,  tbl[i].exp_first);
      check($sformatf("vec%0d second_row", i), second_row_fixed, tbl[i].exp_second);
      check($sformatf("vec%0d constant", i),   RW'(constant),    RW'(tbl[i].exp_const));
      check($sformatf("vec%0d op", i),         RW'(op),          RW'(tbl[i].exp_op));
      if (tbl[i].chk_res) check($sformatf("vec%0d res_rd_data", i), res_rd_data, tbl[i].exp_res);
      $display("vec %0d: core_reset=%0b busy=%0b done=%0b err=%0b", i, core_reset, busy, done, err);
    end
    clr();

    // ---------------- restart from DONE, simultaneous request/write ----------------
    start = 1'b1; cfg_constant = 32'h77; cfg_op = 1'b0;
    step(); clr();
    check_status("restart", 1'b0, 1'b1, 1'b0, 1'b0);
    check("restart first_row", first_row_fixed, R1);
    check("restart second_row", second_row_fixed, S1);
    check("restart constant", RW'(constant), RW'(32'h77));
    check("restart op", RW'(op), Z);
    read_again = 1'b1; result_mem_we = 1'b1; vXc_add_8_output = RC;
    step(); clr();
    check_status("simul", 1'b0, 1'b1, 1'b0, 1'b0);
    check("simul first_row", first_row_fixed, R2);
    check("simul second_row", second_row_fixed, S2);
    $display("simultaneous read_again+result_mem_we: first_row=%h", first_row_fixed[EW-1:0]);
    read_again = 1'b1;
    step(); clr();
    check_status("extra_read", 1'b0, 1'b1, 1'b0, 1'b1);
    check("extra_read first_row", first_row_fixed, R2);
    result_mem_we = 1'b1; vXc_add_8_output = RD;
    step(); clr();
    check_status("second_write", 1'b1, 1'b0, 1'b1, 1'b1);
    res_rd_addr = 1'b0;
    step();
    check("readback0", res_rd_data, RC);
    check("done_pulse_end", RW'(done), Z);
    res_rd_addr = 1'b1;
    step();
    check("readback1", res_rd_data, RD);
    $display("restart pass: results %h %h", RC[EW-1:0], res_rd_data[EW-1:0]);

    // ---------------- result write in IDLE ----------------
    reset = 1'b1; step(); reset = 1'b0;
    check_status("reset2", 1'b1, 1'b0, 1'b0, 1'b0);
    result_mem_we = 1'b1; vXc_add_8_output = RE; res_rd_addr = 1'b0;
    step(); clr();
    check_status("idle_write", 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    check("idle_write no_store", res_rd_data, RC);
    $display("result_mem_we in IDLE: err=%0b", err);

    // ---------------- start clears err; write pointer untouched ----------------
    start = 1'b1; cfg_constant = 32'h33; cfg_op = 1'b1;
    step(); clr();
    check_status("start3", 1'b0, 1'b1, 1'b0, 1'b0);
    result_mem_we = 1'b1; vXc_add_8_output = RF;
    step(); clr();
    check_status("first_write3", 1'b0, 1'b1, 1'b0, 1'b0);
    load_we = 1'b1; load_sel = 1'b0; load_addr = 1'b0; load_data = RE;
    step(); clr();
    check("busy_load first_row", first_row_fixed, R1);

    // ---------------- mid-pass reset and clean restart ----------------
    reset = 1'b1; step(); reset = 1'b0;
    check_status("mid_reset", 1'b1, 1'b0, 1'b0, 1'b0);
    check("mid_reset first_row", first_row_fixed, Z);
    check("mid_reset constant", RW'(constant), Z);
    start = 1'b1; cfg_constant = 32'h99; cfg_op = 1'b1;
    step(); clr();
    check_status("restart4", 1'b0, 1'b1, 1'b0, 1'b0);
    check("restart4 first_row", first_row_fixed, R1);
    check("restart4 constant", RW'(constant), RW'(32'h99));
    read_again = 1'b1; result_mem_we = 1'b1; vXc_add_8_output = RG;
    step(); clr();
    result_mem_we = 1'b1; vXc_add_8_output = RH;
    step(); clr();
    check_status("pass4 end", 1'b1, 1'b0, 1'b1, 1'b0);
    res_rd_addr = 1'b1;
    step();
    check("pass4 readback1", res_rd_data, RH);
    res_rd_addr = 1'b0;
    step();
    check("pass4 readback0", res_rd_data, RG);
    $display("pass after mid-pass reset: err=%0b", err);

`ifdef VXC_ROW_SERVER_TIMEOUT_EN
    // ---------------- watchdog ----------------
    start = 1'b1;
    step(); clr();
    n = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      n++;
      if (done) break;
    end
    check("timeout cycles", RW'(n), RW'(64));
    check_status("timeout", 1'b1, 1'b0, 1'b1, 1'b1);
    $display("watchdog fired after %0d cycles", n);
`endif

    // ---------------- randomized phase against the reference model ----------------
    reset = 1'b1; step(); reset = 1'b0;
    m_ops[0][0] = R1; m_ops[0][1] = R2;
    m_ops[1][0] = S1; m_ops[1][1] = S2;
    m_res[0] = RG; m_res[1] = RH;
    m_res_valid[0] = 1'b1; m_res_valid[1] = 1'b1;
    m_idle = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
    m_rd = 0; m_wr = 0; m_first = Z; m_second = Z; m_const = '0; m_op = 1'b0;
    passes = 0;

    for (int cyc = 0; cyc < 400; cyc++) begin
      int r;
      clr();
      load_sel         = 1'($urandom_range(0, 1));
      load_addr        = AW'($urandom_range(0, NR - 1));
      load_data        = rand_row();
      cfg_constant     = $urandom();
      cfg_op           = 1'($urandom_range(0, 1));
      vXc_add_8_output = rand_row();
      res_rd_addr      = AW'($urandom_range(0, NR - 1));
      if (!m_busy) begin
        r = $urandom_range(0, 9);
        if (r < 2)      start = 1'b1;
        else if (r < 6) load_we = 1'b1;
        else if (r == 6) result_mem_we = 1'b1;
      end else begin
        read_again    = ($urandom_range(0, 2) == 0);
        result_mem_we = ($urandom_range(0, 2) == 0);
        start         = ($urandom_range(0, 7) == 0);
        load_we       = ($urandom_range(0, 7) == 0);
      end

      // Model: readback sees contents before this cycle's write.
      exp_res       = m_res[res_rd_addr];
      exp_res_valid = m_res_valid[res_rd_addr];
      m_done = 1'b0;
      if (!m_busy) begin
        if (load_we && m_idle) m_ops[load_sel][load_addr] = load_data;
        if (result_mem_we) m_err = 1'b1;
        if (start) begin
          m_idle = 1'b0; m_busy = 1'b1; m_rd = 1; m_wr = 0; m_err = 1'b0;
          m_first = m_ops[0][0]; m_second = m_ops[1][0];
          m_const = cfg_constant; m_op = cfg_op;
        end
      end else begin
        if (read_again) begin
          if (m_rd < NR) begin
            m_first = m_ops[0][m_rd]; m_second = m_ops[1][m_rd]; m_rd++;
          end else begin
            m_err = 1'b1;
          end
        end
        if (result_mem_we) begin
          m_res[m_wr] = vXc_add_8_output; m_res_valid[m_wr] = 1'b1; m_wr++;
          if (m_wr == NR) begin m_busy = 1'b0; m_done = 1'b1; end
        end
      end

      step();
      check_status($sformatf("rnd%0d", cyc), !m_busy, m_busy, m_done, m_err);
      check($sformatf("rnd%0d first_row", cyc),  first_row_fixed,  m_first);
      check($sformatf("rnd%0d second_row", cyc), second_row_fixed, m_second);
      check($sformatf("rnd%0d constant", cyc),   RW'(constant),    RW'(m_const));
      check($sformatf("rnd%0d op", cyc),         RW'(op),          RW'(m_op));
      if (exp_res_valid) check($sformatf("rnd%0d res_rd_data", cyc), res_rd_data, exp_res);
      if (m_done) begin
        passes++;
        $display("random pass %0d complete at cycle %0d, err=%0b", passes, cyc, err);
      end
    end
    clr();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
